// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIVIDEND_W_DEF = 32;
  localparam int DIVISOR_W_DEF  = 16;

  function automatic int cnt_width(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider; master drives operands, slave is the divider.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, subtract b if it fits.
module div_step #(
  parameter int DIVISOR_W = 16
) (
  input  logic [DIVISOR_W:0]   r,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] b,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 q_bit
);
  logic [DIVISOR_W+1:0] shifted;

  // r[DIVISOR_W] is zero whenever b != 0, and with b == 0 the compare always passes,
  // so keeping it in the compare changes nothing.
  assign shifted = {r, dividend_bit};

  always_comb begin
    q_bit  = (shifted >= {2'b00, b});
    r_next = q_bit ? (shifted[DIVISOR_W:0] - {1'b0, b}) : shifted[DIVISOR_W:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned divider (radix-2 restoring, one quotient bit per clock).
// Optional: define SEQ_DIVIDER_ZERO_FAST_EN to send divide-by-zero straight to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  // state | meaning
  // IDLE  | in_ready=1, waiting for an operation
  // CALC  | one restoring step per edge, count = steps remaining
  // DONE  | result held with out_valid=1 until out_ready
  localparam int CNT_BITS = cnt_width(DIVIDEND_W);

  div_state_t            state, state_nxt;
  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  b_reg;
  logic [DIVISOR_W:0]    r_reg, r_step;
  logic [CNT_BITS-1:0]   count;
  logic                  dbz_reg, q_bit, zero_fast;
  logic                  in_ready_c, out_valid_c;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  assign zero_fast = (bus.divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .r            (r_reg),
    .dividend_bit (q_reg[DIVIDEND_W-1]),
    .b            (b_reg),
    .r_next       (r_step),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = zero_fast ? DONE : CALC;
      end
      CALC: if (count == CNT_BITS'(1)) state_nxt = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg   <= '0;
      b_reg   <= '0;
      r_reg   <= '0;
      count   <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          b_reg   <= bus.divisor;
          dbz_reg <= (bus.divisor == '0);
          count   <= CNT_BITS'(DIVIDEND_W);
          if (zero_fast) begin
            // Same values the full iteration would produce with b == 0.
            q_reg <= '1;
            r_reg <= {1'b0, bus.dividend[DIVISOR_W-1:0]};
          end else begin
            q_reg <= bus.dividend;
            r_reg <= '0;
          end
        end
        CALC: begin
          r_reg <= r_step;
          q_reg <= {q_reg[DIVIDEND_W-2:0], q_bit};
          count <= count - CNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg[DIVISOR_W-1:0];
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus a randomized back-to-back stream.
`timescale 1ns/1ps
module tb_seq_divider;
  localparam int AW = 32;
  localparam int BW = 16;
  localparam int N_RAND = 1000;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  localparam int ZERO_LAT = 0;   // DONE is entered on the accepting edge itself
`else
  localparam int ZERO_LAT = AW;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errors = 0;

  seq_divider_if #(.DIVIDEND_W(AW), .DIVISOR_W(BW)) dif ();
  seq_divider #(.DIVIDEND_W(AW), .DIVISOR_W(BW)) dut (.clk(clk), .rst_n(rst_n), .bus(dif));

  always #5 clk = ~clk;

  function automatic void model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                output logic [AW-1:0] q, output logic [BW-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = a[BW-1:0];
      z = 1'b1;
    end else begin
      q = a / {16'h0, b};
      r = BW'(a % {16'h0, b});
      z = 1'b0;
    end
  endfunction

  task automatic rand_pair(output logic [AW-1:0] a, output logic [BW-1:0] b);
    case ($urandom_range(0, 5))
      0:       b = '0;
      1:       b = 16'd1;
      2:       b = BW'($urandom_range(2, 255));
      default: b = BW'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) a = AW'($urandom_range(0, 300));
    else                           a = $urandom;
  endtask

  // Drives one operation from IDLE; lat = edges after the accepting edge until out_valid (-1 on timeout).
  task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b, output int lat);
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(negedge clk);
    dif.in_valid = 1'b0;
    lat = 0;
    while (!dif.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!dif.out_valid) lat = -1;
  endtask

  task automatic retire();
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", dif.in_ready); end
    vectors++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", dif.out_valid); end
    vectors++; if (dif.quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient got %h want 0", dif.quotient); end
    vectors++; if (dif.remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder got %h want 0", dif.remainder); end
    vectors++; if (dif.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", dif.div_by_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    issue(32'd100, 16'd7, lat);
    vectors++; if (lat != AW) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, AW); end
    vectors++;
    if (dif.quotient !== 32'd14 || dif.remainder !== 16'd2 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d z=%b want q=14 r=2 z=0", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    retire();
  endtask

  task automatic test_max();
    int lat;
    issue(32'hFFFF_FFFF, 16'hFFFF, lat);
    vectors++;
    if (dif.quotient !== 32'h0001_0001 || dif.remainder !== 16'h0 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL max_result got q=%h r=%h z=%b want q=00010001 r=0000 z=0", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    retire();
  endtask

  task automatic test_div_zero();
    int lat;
    issue(32'h1234_5678, 16'h0, lat);
    vectors++; if (lat != ZERO_LAT) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, ZERO_LAT); end
    vectors++;
    if (dif.quotient !== 32'hFFFF_FFFF || dif.remainder !== 16'h5678 || dif.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL zero_result got q=%h r=%h z=%b want q=ffffffff r=5678 z=1", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    retire();
  endtask

  task automatic test_stall();
    int lat;
    int bad = 0;
    issue(32'd5, 16'd9, lat);
    dif.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // Offer a competing operation; it must be ignored while DONE.
      dif.in_valid = 1'b1;
      dif.dividend = 32'd77;
      dif.divisor  = 16'd3;
      @(negedge clk);
      if (dif.out_valid !== 1'b1 || dif.in_ready !== 1'b0 || dif.quotient !== 32'd0 || dif.remainder !== 16'd5) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles want 0", bad); end
    dif.in_valid = 1'b0;
    retire();
    vectors++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got in_ready=%b out_valid=%b want 1 0", dif.in_ready, dif.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int spurious = 0;
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 16'd3;
    @(negedge clk);
    dif.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (dif.in_ready !== 1'b1 || dif.out_valid !== 1'b0 || dif.quotient !== 32'h0 ||
        dif.remainder !== 16'h0 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got rdy=%b vld=%b q=%h r=%h z=%b want 1 0 0 0 0",
                         dif.in_ready, dif.out_valid, dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (dif.out_valid !== 1'b0) spurious++;
    end
    vectors++; if (spurious != 0) begin errors++; $display("FAIL midreset_no_output got %0d valid cycles want 0", spurious); end
    issue(32'd1000, 16'd3, lat);
    vectors++;
    if (lat != AW || dif.quotient !== 32'd333 || dif.remainder !== 16'd1) begin
      errors++; $display("FAIL midreset_rerun got lat=%0d q=%0d r=%0d want lat=%0d q=333 r=1", lat, dif.quotient, dif.remainder, AW);
    end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] qa[$];
    logic [BW-1:0] qb[$];
    logic [AW-1:0] na, ea, eq;
    logic [BW-1:0] nb, eb, er;
    logic          ez;
    longint unsigned recon;
    int sent = 0, got = 0, cyc = 0;
    rand_pair(na, nb);
    @(negedge clk);
    while (got < N_RAND && cyc < 60000) begin
      // DUT outputs are stable until the coming rising edge, so decide both transfers now.
      dif.out_ready = ($urandom_range(0, 3) != 0);
      if (dif.out_valid && dif.out_ready) begin
        vectors++;
        if (qa.size() == 0) begin
          errors++; $display("FAIL b2b_duplicate got extra result q=%h want none", dif.quotient);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          model(ea, eb, eq, er, ez);
          if (dif.quotient !== eq || dif.remainder !== er || dif.div_by_zero !== ez) begin
            errors++; $display("FAIL b2b_result a=%h b=%h got q=%h r=%h z=%b want q=%h r=%h z=%b",
                               ea, eb, dif.quotient, dif.remainder, dif.div_by_zero, eq, er, ez);
          end
          if (eb != '0) begin
            vectors++;
            recon = 64'(dif.quotient) * 64'(eb) + 64'(dif.remainder);
            if (recon != 64'(ea) || dif.remainder >= eb) begin
              errors++; $display("FAIL b2b_identity a=%h b=%h got q*b+r=%h r=%h want %h r<b", ea, eb, recon, dif.remainder, ea);
            end
          end
        end
        got++;
      end
      if (sent < N_RAND) begin
        dif.in_valid = 1'b1;
        dif.dividend = na;
        dif.divisor  = nb;
        if (dif.in_ready) begin
          qa.push_back(na);
          qb.push_back(nb);
          sent++;
          rand_pair(na, nb);
        end
      end else begin
        dif.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    vectors++;
    if (got != N_RAND || sent != N_RAND || qa.size() != 0) begin
      errors++; $display("FAIL b2b_count got sent=%0d received=%0d pending=%0d want %0d %0d 0", sent, got, qa.size(), N_RAND, N_RAND);
    end
  endtask

  initial begin
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
